// File: rtl/br_decode_stage_pkg.sv
// Shared widths, opcodes, ALU codes and the per-lane decoded payload for the branch decode stage.
package br_decode_stage_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned REG_AW   = 5;
  localparam int unsigned ALUOP_W  = 8;
  localparam int unsigned ALUSEL_W = 3;
  localparam int unsigned OPC_W    = 6;

  localparam logic [OPC_W-1:0] JIRL_OPCODE = 6'h13;
  localparam logic [OPC_W-1:0] B_OPCODE    = 6'h14;
  localparam logic [OPC_W-1:0] BL_OPCODE   = 6'h15;
  localparam logic [OPC_W-1:0] BEQ_OPCODE  = 6'h16;
  localparam logic [OPC_W-1:0] BNE_OPCODE  = 6'h17;
  localparam logic [OPC_W-1:0] BLT_OPCODE  = 6'h18;
  localparam logic [OPC_W-1:0] BGE_OPCODE  = 6'h19;
  localparam logic [OPC_W-1:0] BLTU_OPCODE = 6'h1A;
  localparam logic [OPC_W-1:0] BGEU_OPCODE = 6'h1B;

  localparam logic [ALUOP_W-1:0] ALU_NOP  = 8'h00;
  localparam logic [ALUOP_W-1:0] ALU_BEQ  = 8'h50;
  localparam logic [ALUOP_W-1:0] ALU_BNE  = 8'h51;
  localparam logic [ALUOP_W-1:0] ALU_BLT  = 8'h52;
  localparam logic [ALUOP_W-1:0] ALU_BGE  = 8'h53;
  localparam logic [ALUOP_W-1:0] ALU_BLTU = 8'h54;
  localparam logic [ALUOP_W-1:0] ALU_BGEU = 8'h55;
  localparam logic [ALUOP_W-1:0] ALU_B    = 8'h56;
  localparam logic [ALUOP_W-1:0] ALU_BL   = 8'h57;
  localparam logic [ALUOP_W-1:0] ALU_JIRL = 8'h58;

  localparam logic [ALUSEL_W-1:0] ALU_SEL_NOP         = 3'b000;
  localparam logic [ALUSEL_W-1:0] ALU_SEL_JUMP_BRANCH = 3'b101;

  typedef struct packed {
    logic                lane_valid;
    logic [ALUOP_W-1:0]  aluop;
    logic [ALUSEL_W-1:0] alusel;
    logic [XLEN-1:0]     imm;
    logic [XLEN-1:0]     target;
    logic                reg1_en;
    logic [REG_AW-1:0]   reg1_addr;
    logic                reg2_en;
    logic [REG_AW-1:0]   reg2_addr;
    logic                rd_we;
    logic [REG_AW-1:0]   rd_addr;
  } lane_dec_t;

endpackage

// File: rtl/br_decode_stage_if.sv
// Instbuffer-side input bundle, dispatch-side output bundle and early redirect of the decode stage.
interface br_decode_stage_if #(
  parameter int unsigned W = 2
);
  import br_decode_stage_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [W-1:0]          in_lane_valid;
  logic [XLEN*W-1:0]     in_pc;
  logic [XLEN*W-1:0]     in_inst;
  logic [W-1:0]          in_pred_taken;
  logic [XLEN*W-1:0]     in_pred_target;

  logic                  out_valid;
  logic                  out_ready;
  logic [W-1:0]          out_lane_valid;
  logic [ALUOP_W*W-1:0]  out_aluop;
  logic [ALUSEL_W*W-1:0] out_alusel;
  logic [XLEN*W-1:0]     out_imm;
  logic [XLEN*W-1:0]     out_target;
  logic [W-1:0]          out_reg1_en;
  logic [REG_AW*W-1:0]   out_reg1_addr;
  logic [W-1:0]          out_reg2_en;
  logic [REG_AW*W-1:0]   out_reg2_addr;
  logic [W-1:0]          out_rd_we;
  logic [REG_AW*W-1:0]   out_rd_addr;

  logic                  redirect_valid;
  logic [XLEN-1:0]       redirect_pc;

  modport slave (
    input  in_valid, in_lane_valid, in_pc, in_inst, in_pred_taken, in_pred_target, out_ready,
    output in_ready, out_valid, out_lane_valid, out_aluop, out_alusel, out_imm, out_target,
           out_reg1_en, out_reg1_addr, out_reg2_en, out_reg2_addr, out_rd_we, out_rd_addr,
           redirect_valid, redirect_pc
  );

  modport master (
    output in_valid, in_lane_valid, in_pc, in_inst, in_pred_taken, in_pred_target, out_ready,
    input  in_ready, out_valid, out_lane_valid, out_aluop, out_alusel, out_imm, out_target,
           out_reg1_en, out_reg1_addr, out_reg2_en, out_reg2_addr, out_rd_we, out_rd_addr,
           redirect_valid, redirect_pc
  );

endinterface

// File: rtl/br_decode_stage_lane_decode.sv
// One lane: branch decode, offset, pc-relative target and static mispredict check (combinational).
module br_lane_decode
  import br_decode_stage_pkg::*;
(
  input  logic            lane_valid,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] inst,
  input  logic            pred_taken,
  input  logic [XLEN-1:0] pred_target,
  output lane_dec_t       dec_c,
  output logic            mispredict_c,
  output logic [XLEN-1:0] redirect_pc_c
);

  logic [XLEN-1:0] off16;
  logic [XLEN-1:0] off26;
  logic            is_cond;
  logic            is_jump;

  // Decode the lane and decide whether its prediction can be corrected now
  always_comb begin
    dec_c         = '0;
    mispredict_c  = 1'b0;
    redirect_pc_c = '0;
    is_cond       = 1'b0;
    is_jump       = 1'b0;
    off16         = {{14{inst[25]}}, inst[25:10], 2'b00};
    off26         = {{4{inst[9]}}, inst[9:0], inst[25:10], 2'b00};
    if (lane_valid) begin
      case (inst[31:26])
        JIRL_OPCODE: begin
          dec_c.aluop     = ALU_JIRL;
          dec_c.imm       = off16;
          dec_c.reg1_en   = 1'b1;
          dec_c.reg1_addr = inst[9:5];
          dec_c.rd_we     = 1'b1;
          dec_c.rd_addr   = inst[4:0];
        end
        B_OPCODE: begin
          dec_c.aluop = ALU_B;
          is_jump     = 1'b1;
        end
        BL_OPCODE: begin
          dec_c.aluop   = ALU_BL;
          is_jump       = 1'b1;
          dec_c.rd_we   = 1'b1;
          dec_c.rd_addr = REG_AW'(1);
        end
        BEQ_OPCODE:  begin dec_c.aluop = ALU_BEQ;  is_cond = 1'b1; end
        BNE_OPCODE:  begin dec_c.aluop = ALU_BNE;  is_cond = 1'b1; end
        BLT_OPCODE:  begin dec_c.aluop = ALU_BLT;  is_cond = 1'b1; end
        BGE_OPCODE:  begin dec_c.aluop = ALU_BGE;  is_cond = 1'b1; end
        BLTU_OPCODE: begin dec_c.aluop = ALU_BLTU; is_cond = 1'b1; end
        BGEU_OPCODE: begin dec_c.aluop = ALU_BGEU; is_cond = 1'b1; end
        default: ;
      endcase
      if (is_jump) begin
        dec_c.imm    = off26;
        dec_c.target = pc + off26;
      end
      if (is_cond) begin
        dec_c.imm       = off16;
        dec_c.target    = pc + off16;
        dec_c.reg1_en   = 1'b1;
        dec_c.reg1_addr = inst[9:5];
        dec_c.reg2_en   = 1'b1;
        dec_c.reg2_addr = inst[4:0];
      end
      dec_c.lane_valid = (dec_c.aluop != ALU_NOP);
      dec_c.alusel     = dec_c.lane_valid ? ALU_SEL_JUMP_BRANCH : ALU_SEL_NOP;
      if (is_jump && (!pred_taken || (pred_target != dec_c.target))) begin
        mispredict_c  = 1'b1;
        redirect_pc_c = dec_c.target;
      end else if (is_cond && pred_taken && (pred_target != dec_c.target)) begin
        mispredict_c  = 1'b1;
        redirect_pc_c = dec_c.target;
      end else if (!dec_c.lane_valid && pred_taken) begin
        mispredict_c  = 1'b1;
        redirect_pc_c = pc + XLEN'(4);
      end
    end
  end

endmodule

// File: rtl/br_decode_stage.sv
// Multi-lane branch decode stage: lane kill priority, 2-entry output skid FIFO and early redirect.
module br_decode_stage
  import br_decode_stage_pkg::*;
#(
  parameter int unsigned DECODE_WIDTH = 2,
  parameter int unsigned SKID_DEPTH   = 2
) (
  input logic              aclk,
  input logic              aresetn,
  input logic              flush,
  br_decode_stage_if.slave bus
);

  localparam int unsigned W     = DECODE_WIDTH;
  localparam int unsigned CNT_W = 2;

  lane_dec_t [W-1:0]     dec_c;
  lane_dec_t [W-1:0]     kill_dec_c;
  logic      [W-1:0]     mis_c;
  logic      [XLEN-1:0]  lane_rpc_c [W];
  logic                  hit_c;
  logic      [XLEN-1:0]  hit_pc_c;

  lane_dec_t [W-1:0]     ent0_q, ent1_q, ent0_d, ent1_d;
  logic      [CNT_W-1:0] count_q, count_d;
  logic                  out_valid_q, out_valid_d;
  logic                  rv_q, rv_d;
  logic      [XLEN-1:0]  rpc_q, rpc_d;
  logic                  accept_c;
  logic                  pop_c;

  for (genvar g = 0; g < W; g++) begin : g_lane
    br_lane_decode u_lane (
      .lane_valid    (bus.in_lane_valid[g]),
      .pc            (bus.in_pc[g*XLEN +: XLEN]),
      .inst          (bus.in_inst[g*XLEN +: XLEN]),
      .pred_taken    (bus.in_pred_taken[g]),
      .pred_target   (bus.in_pred_target[g*XLEN +: XLEN]),
      .dec_c         (dec_c[g]),
      .mispredict_c  (mis_c[g]),
      .redirect_pc_c (lane_rpc_c[g])
    );

    assign bus.out_lane_valid[g]                   = ent0_q[g].lane_valid;
    assign bus.out_aluop[g*ALUOP_W +: ALUOP_W]     = ent0_q[g].aluop;
    assign bus.out_alusel[g*ALUSEL_W +: ALUSEL_W]  = ent0_q[g].alusel;
    assign bus.out_imm[g*XLEN +: XLEN]             = ent0_q[g].imm;
    assign bus.out_target[g*XLEN +: XLEN]          = ent0_q[g].target;
    assign bus.out_reg1_en[g]                      = ent0_q[g].reg1_en;
    assign bus.out_reg1_addr[g*REG_AW +: REG_AW]   = ent0_q[g].reg1_addr;
    assign bus.out_reg2_en[g]                      = ent0_q[g].reg2_en;
    assign bus.out_reg2_addr[g*REG_AW +: REG_AW]   = ent0_q[g].reg2_addr;
    assign bus.out_rd_we[g]                        = ent0_q[g].rd_we;
    assign bus.out_rd_addr[g*REG_AW +: REG_AW]     = ent0_q[g].rd_addr;
  end

  // Oldest mispredicting lane wins the redirect; every younger lane is dropped from the bundle
  always_comb begin
    kill_dec_c = dec_c;
    hit_c      = 1'b0;
    hit_pc_c   = '0;
    for (int i = 0; i < int'(W); i++) begin
      if (hit_c) begin
        kill_dec_c[i].lane_valid = 1'b0;
      end else if (mis_c[i]) begin
        hit_c    = 1'b1;
        hit_pc_c = lane_rpc_c[i];
      end
    end
  end

  // The cycle after a redirect carries wrong-path instructions, so the stage refuses them
  assign bus.in_ready       = (count_q < CNT_W'(SKID_DEPTH)) && !rv_q;
  assign bus.out_valid      = out_valid_q;
  assign bus.redirect_valid = rv_q;
  assign bus.redirect_pc    = rpc_q;
  assign accept_c           = bus.in_valid && bus.in_ready && !flush;
  assign pop_c              = out_valid_q && bus.out_ready;

  // Skid FIFO next state: entry 0 is always the head so outputs come straight from flops
  always_comb begin
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;
    count_d = count_q;
    rv_d    = 1'b0;
    rpc_d   = rpc_q;
    if (flush) begin
      count_d = '0;
    end else begin
      case ({accept_c, pop_c})
        2'b10: begin
          if (count_q == '0) ent0_d = kill_dec_c;
          else               ent1_d = kill_dec_c;
          count_d = count_q + CNT_W'(1);
        end
        2'b01: begin
          ent0_d  = ent1_q;
          count_d = count_q - CNT_W'(1);
        end
        2'b11: ent0_d = kill_dec_c;
        default: ;
      endcase
      if (accept_c && hit_c) begin
        rv_d  = 1'b1;
        rpc_d = hit_pc_c;
      end
    end
    out_valid_d = (count_d != '0);
  end

  // State registers
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ent0_q      <= '0;
      ent1_q      <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      rv_q        <= 1'b0;
      rpc_q       <= '0;
    end else begin
      ent0_q      <= ent0_d;
      ent1_q      <= ent1_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      rv_q        <= rv_d;
      rpc_q       <= rpc_d;
    end
  end

endmodule

// File: tb/tb_br_decode_stage.sv
// Self-checking bench for br_decode_stage: vector table plus skid/flush/reset sequences.
module tb_br_decode_stage;
  import br_decode_stage_pkg::*;

  typedef struct packed {
    logic [1:0]  lv;
    logic [7:0]  op0;
    logic [2:0]  sel0;
    logic [31:0] imm0;
    logic [31:0] tgt0;
    logic        r1en0;
    logic [4:0]  r1a0;
    logic        r2en0;
    logic [4:0]  r2a0;
    logic        we0;
    logic [4:0]  wa0;
    logic [7:0]  op1;
    logic [31:0] imm1;
    logic [31:0] tgt1;
  } exp_t;

  typedef struct {
    logic [1:0]  lane_v;
    logic [31:0] pc0, inst0, ptg0;
    logic        pt0;
    logic [31:0] pc1, inst1, ptg1;
    logic        pt1;
    exp_t        e;
    logic        rv;
    logic [31:0] rpc;
  } vec_t;

  localparam logic [31:0] ADD_W = 32'h0010_0C41;
  localparam logic [2:0]  JB    = ALU_SEL_JUMP_BRANCH;
  localparam logic [2:0]  SN    = ALU_SEL_NOP;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;
  int   n_pop = 0;
  exp_t exp_q[$];
  vec_t vt[8];

  br_decode_stage_if #(.W(2)) bus ();

  br_decode_stage #(.DECODE_WIDTH(2), .SKID_DEPTH(2)) dut (
    .aclk    (clk),
    .aresetn (rst_n),
    .flush   (flush),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] e16(logic [5:0] op, logic [15:0] off, logic [4:0] rj, logic [4:0] rd);
    return {op, off, rj, rd};
  endfunction

  function automatic logic [31:0] e26(logic [5:0] op, logic [25:0] off);
    return {op, off[15:0], off[25:16]};
  endfunction

  function automatic exp_t ex(logic [1:0] lv, logic [7:0] op0, logic [2:0] sel0, logic [31:0] imm0,
                              logic [31:0] tgt0, logic r1en, logic [4:0] r1a, logic r2en, logic [4:0] r2a,
                              logic we, logic [4:0] wa, logic [7:0] op1, logic [31:0] imm1, logic [31:0] tgt1);
    exp_t e;
    e = '{lv, op0, sel0, imm0, tgt0, r1en, r1a, r2en, r2a, we, wa, op1, imm1, tgt1};
    return e;
  endfunction

  function automatic vec_t vc(logic [1:0] lane_v, logic [31:0] pc0, logic [31:0] inst0, logic pt0,
                              logic [31:0] ptg0, logic [31:0] pc1, logic [31:0] inst1, logic pt1,
                              logic [31:0] ptg1, exp_t e, logic rv, logic [31:0] rpc);
    vec_t v;
    v.lane_v = lane_v; v.pc0 = pc0; v.inst0 = inst0; v.pt0 = pt0; v.ptg0 = ptg0;
    v.pc1 = pc1; v.inst1 = inst1; v.pt1 = pt1; v.ptg1 = ptg1;
    v.e = e; v.rv = rv; v.rpc = rpc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic chk_bundle(input exp_t act, input exp_t req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL bundle actual=%h required=%h", act, req);
    end
  endtask

  task automatic drive(input vec_t v, input logic valid);
    bus.in_valid       = valid;
    bus.in_lane_valid  = v.lane_v;
    bus.in_pc          = {v.pc1, v.pc0};
    bus.in_inst        = {v.inst1, v.inst0};
    bus.in_pred_taken  = {v.pt1, v.pt0};
    bus.in_pred_target = {v.ptg1, v.ptg0};
  endtask

  task automatic idle();
    bus.in_valid       = 1'b0;
    bus.in_lane_valid  = '0;
    bus.in_pc          = '0;
    bus.in_inst        = '0;
    bus.in_pred_taken  = '0;
    bus.in_pred_target = '0;
  endtask

  // Offer a bundle until accepted, then record its expected output
  task automatic send(input int idx);
    int wait_cyc;
    wait_cyc = 0;
    @(posedge clk); #1;
    drive(vt[idx], 1'b1);
    @(negedge clk);
    while (!bus.in_ready && wait_cyc < 40) begin
      @(negedge clk);
      wait_cyc++;
    end
    if (!bus.in_ready) begin
      n_chk++; n_err++;
      $display("FAIL accept_timeout vec=%0d actual=not_accepted required=accepted", idx);
      @(posedge clk); #1;
      idle();
      return;
    end
    @(posedge clk);
    exp_q.push_back(vt[idx].e);
    #1;
    idle();
  endtask

  task automatic drain();
    int cyc;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 30) begin
      @(negedge clk);
      cyc++;
    end
    chk("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  // Scoreboard: compare each handshaked output bundle against the oldest expectation
  always @(negedge clk) begin
    exp_t act, e;
    if (rst_n && !flush && bus.out_valid && bus.out_ready) begin
      act = '{bus.out_lane_valid, bus.out_aluop[7:0], bus.out_alusel[2:0], bus.out_imm[31:0],
              bus.out_target[31:0], bus.out_reg1_en[0], bus.out_reg1_addr[4:0], bus.out_reg2_en[0],
              bus.out_reg2_addr[4:0], bus.out_rd_we[0], bus.out_rd_addr[4:0], bus.out_aluop[15:8],
              bus.out_imm[63:32], bus.out_target[63:32]};
      if (exp_q.size() == 0) begin
        n_chk++; n_err++;
        $display("FAIL unexpected_bundle actual=%h required=none", act);
      end else begin
        e = exp_q.pop_front();
        chk_bundle(act, e);
        n_pop++;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    vt[0] = vc(2'b11, 32'h1C00_0000, e16(BEQ_OPCODE, 16'h0004, 5'd1, 5'd2), 1'b0, 32'h0,
               32'h1C00_0004, ADD_W, 1'b0, 32'h0,
               ex(2'b01, ALU_BEQ, JB, 32'h10, 32'h1C00_0010, 1, 5'd1, 1, 5'd2, 0, 5'd0, ALU_NOP, 32'h0, 32'h0),
               1'b0, 32'h0);
    vt[1] = vc(2'b11, 32'h1C00_0100, e26(B_OPCODE, 26'h3FF_FFFF), 1'b0, 32'h0,
               32'h1C00_0104, e16(BEQ_OPCODE, 16'h0001, 5'd0, 5'd0), 1'b0, 32'h0,
               ex(2'b01, ALU_B, JB, 32'hFFFF_FFFC, 32'h1C00_00FC, 0, 5'd0, 0, 5'd0, 0, 5'd0, ALU_BEQ, 32'h4, 32'h1C00_0108),
               1'b1, 32'h1C00_00FC);
    vt[2] = vc(2'b11, 32'h1C00_0200, ADD_W, 1'b1, 32'h1234_5678,
               32'h1C00_0204, e26(B_OPCODE, 26'h2), 1'b1, 32'h1C00_020C,
               ex(2'b00, ALU_NOP, SN, 32'h0, 32'h0, 0, 5'd0, 0, 5'd0, 0, 5'd0, ALU_B, 32'h8, 32'h1C00_020C),
               1'b1, 32'h1C00_0204);
    vt[3] = vc(2'b11, 32'h1C00_1000, e26(BL_OPCODE, 26'h100), 1'b1, 32'h1C00_1400,
               32'h1C00_1004, e16(JIRL_OPCODE, 16'hFFFF, 5'd5, 5'd1), 1'b1, 32'h0,
               ex(2'b11, ALU_BL, JB, 32'h400, 32'h1C00_1400, 0, 5'd0, 0, 5'd0, 1, 5'd1, ALU_JIRL, 32'hFFFF_FFFC, 32'h0),
               1'b0, 32'h0);
    vt[4] = vc(2'b11, 32'h1C00_2000, e16(BNE_OPCODE, 16'h8000, 5'd3, 5'd4), 1'b1, 32'h1C00_2000,
               32'h1C00_2004, e16(BGEU_OPCODE, 16'h0002, 5'd6, 5'd7), 1'b0, 32'h0,
               ex(2'b01, ALU_BNE, JB, 32'hFFFE_0000, 32'h1BFE_2000, 1, 5'd3, 1, 5'd4, 0, 5'd0, ALU_BGEU, 32'h8, 32'h1C00_200C),
               1'b1, 32'h1BFE_2000);
    vt[5] = vc(2'b11, 32'h1C00_3000, e16(BLTU_OPCODE, 16'h0003, 5'd8, 5'd9), 1'b0, 32'h0,
               32'h1C00_3004, e26(BL_OPCODE, 26'h3FF_FFFE), 1'b1, 32'h0,
               ex(2'b11, ALU_BLTU, JB, 32'hC, 32'h1C00_300C, 1, 5'd8, 1, 5'd9, 0, 5'd0, ALU_BL, 32'hFFFF_FFF8, 32'h1C00_2FFC),
               1'b1, 32'h1C00_2FFC);
    vt[6] = vc(2'b01, 32'hFFFF_FFF0, e16(BGE_OPCODE, 16'h0008, 5'd10, 5'd11), 1'b0, 32'h0,
               32'hFFFF_FFF4, e26(B_OPCODE, 26'h1), 1'b0, 32'h0,
               ex(2'b01, ALU_BGE, JB, 32'h20, 32'h10, 1, 5'd10, 1, 5'd11, 0, 5'd0, ALU_NOP, 32'h0, 32'h0),
               1'b0, 32'h0);
    vt[7] = vc(2'b10, 32'h1C00_4000, ADD_W, 1'b1, 32'h0,
               32'h1C00_4004, e16(BLT_OPCODE, 16'h0010, 5'd12, 5'd13), 1'b1, 32'h1C00_4044,
               ex(2'b10, ALU_NOP, SN, 32'h0, 32'h0, 0, 5'd0, 0, 5'd0, 0, 5'd0, ALU_BLT, 32'h40, 32'h1C00_4044),
               1'b0, 32'h0);

    idle();
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
    chk("reset_redirect_valid", 32'(bus.redirect_valid), 32'd0);
    chk("reset_redirect_pc", bus.redirect_pc, 32'd0);
    chk("reset_target0", bus.out_target[31:0], 32'd0);

    // Vector table, one bundle at a time with dispatch always ready
    for (int i = 0; i < 8; i++) begin
      send(i);
      @(negedge clk);
      chk($sformatf("redirect_valid_v%0d", i), 32'(bus.redirect_valid), 32'(vt[i].rv));
      if (vt[i].rv) begin
        chk($sformatf("redirect_pc_v%0d", i), bus.redirect_pc, vt[i].rpc);
        chk($sformatf("in_ready_in_pulse_v%0d", i), 32'(bus.in_ready), 32'd0);
      end
    end
    drain();

    // Back-pressure: three bundles against a stalled dispatch
    base = n_pop;
    bus.out_ready = 1'b0;
    fork
      begin
        send(0);
        send(3);
        send(6);
      end
      begin
        repeat (8) @(negedge clk);
        chk("full_in_ready", 32'(bus.in_ready), 32'd0);
        chk("full_out_valid", 32'(bus.out_valid), 32'd1);
        chk("full_no_pop", 32'(n_pop - base), 32'd0);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
      end
    join
    drain();
    chk("stall_pop_count", 32'(n_pop - base), 32'd3);

    // Flush with two entries, a pop request and an offered bundle in the same cycle
    bus.out_ready = 1'b0;
    send(0);
    send(3);
    @(posedge clk); #1;
    flush = 1'b1;
    bus.out_ready = 1'b1;
    drive(vt[1], 1'b1);
    @(posedge clk); #1;
    flush = 1'b0;
    idle();
    exp_q.delete();
    chk("flush_full_out_valid", 32'(bus.out_valid), 32'd0);
    chk("flush_full_redirect", 32'(bus.redirect_valid), 32'd0);
    chk("flush_full_in_ready", 32'(bus.in_ready), 32'd1);
    send(6);
    drain();

    // Flush drops a redirecting bundle offered in the flush cycle
    bus.out_ready = 1'b0;
    send(0);
    @(posedge clk); #1;
    flush = 1'b1;
    drive(vt[1], 1'b1);
    @(posedge clk); #1;
    flush = 1'b0;
    idle();
    exp_q.delete();
    chk("flush_in_out_valid", 32'(bus.out_valid), 32'd0);
    chk("flush_in_redirect", 32'(bus.redirect_valid), 32'd0);
    bus.out_ready = 1'b1;
    send(4);
    drain();

    // Asynchronous reset with one stored entry and a redirect pulse in flight
    bus.out_ready = 1'b0;
    send(1);
    chk("pre_reset_redirect", 32'(bus.redirect_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_redirect_valid", 32'(bus.redirect_valid), 32'd0);
    chk("arst_redirect_pc", bus.redirect_pc, 32'd0);
    chk("arst_lane_valid", 32'(bus.out_lane_valid), 32'd0);
    chk("arst_imm0", bus.out_imm[31:0], 32'd0);
    chk("arst_aluop", 32'(bus.out_aluop), 32'd0);
    exp_q.delete();
    @(negedge clk) rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("post_reset_in_ready", 32'(bus.in_ready), 32'd1);
    chk("post_reset_out_valid", 32'(bus.out_valid), 32'd0);
    send(7);
    drain();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
